// File: rtl/serial_packer_pkg.sv
// Shared types and constants for the serial byte packer.
package serial_packer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDrain,
    StDone
  } state_e;

  typedef logic [1:0]  lane_t;
  typedef logic [31:0] word_t;

  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty/count and a
// synchronous flush. DEPTH must be a power of two, >= 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  // A push into a full FIFO is only legal when a pop frees a slot on the same edge.
  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != DepthCnt) || do_pop);
  end

  // Pointer and occupancy state; flush empties the FIFO like a reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Head word is forced to zero while empty so the output is clean after reset.
  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == DepthCnt);
    count_o = count_q;
    rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/serial_byte_packer.sv
// Re-packs the serializer's byte stream (byte, valid, lane) into 32-bit
// little-endian words buffered in a FWFT FIFO, framed by a programmable
// word count. Optional statistics counters are built only when
// SERIAL_BYTE_PACKER_STATS_EN is defined; otherwise o_bytes_seen and
// o_err_count are tied to zero.
module serial_byte_packer
  import serial_packer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LEN_W      = 6
) (
  input  logic             SLOW_CLK,
  input  logic             SLOW_RESET,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_RCC_BUFFER_LENGTH,
  input  logic [7:0]       i_serialized_output,
  input  logic             i_serialized_output_valid,
  input  logic [1:0]       i_Serialize_Counter,
  output logic [31:0]      o_word,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic             o_frame_done,
  output logic             o_lane_error,
  output logic             o_overflow,
  output logic [LEN_W:0]   o_words_packed,
  output logic [15:0]      o_bytes_seen,
  output logic [7:0]       o_err_count
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam lane_t LastLane = lane_t'(BYTES_PER_WORD - 1);

  state_e           state_q, state_d;
  logic [LEN_W:0]   len_q, len_d;
  logic [LEN_W:0]   words_q, words_d;
  lane_t            exp_lane_q, exp_lane_d;
  logic             resync_q, resync_d;
  logic [23:0]      partial_q, partial_d;
  logic             lane_err_q, lane_err_d;
  logic             ovf_q, ovf_d;

  logic             lane_err_evt, drop_evt, word_done;
  logic             fifo_push, fifo_pop, fifo_flush;
  logic             fifo_full, fifo_empty;
  logic [CntW-1:0]  fifo_count;
  word_t            fifo_wdata;
  lane_t            lane;

  assign lane = lane_t'(i_Serialize_Counter);

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (SLOW_CLK),
    .rst_i   (SLOW_RESET),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (o_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Frame FSM plus byte assembler: next-state, FIFO push/flush and flag updates.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    words_d      = words_q;
    exp_lane_d   = exp_lane_q;
    resync_d     = resync_q;
    partial_d    = partial_q;
    lane_err_evt = 1'b0;
    drop_evt     = 1'b0;
    word_done    = 1'b0;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;
    fifo_pop     = !fifo_empty && i_word_ready;
    fifo_wdata   = {i_serialized_output, partial_q};

    if (i_start) begin
      // Start or abort: everything frame-scoped is cleared, bytes this cycle ignored.
      state_d    = StCollect;
      len_d      = (i_RCC_BUFFER_LENGTH == '0) ? {1'b1, {LEN_W{1'b0}}}
                                               : {1'b0, i_RCC_BUFFER_LENGTH};
      words_d    = '0;
      exp_lane_d = '0;
      resync_d   = 1'b0;
      partial_d  = '0;
      fifo_flush = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StCollect: begin
          if (i_serialized_output_valid) begin
            if (resync_q && (lane != '0)) begin
              // Still hunting for a lane-0 byte after a sequence error.
            end else if (lane == exp_lane_q) begin
              resync_d   = 1'b0;
              exp_lane_d = exp_lane_q + 1'b1;
              case (lane)
                2'd0:    partial_d[7:0]   = i_serialized_output;
                2'd1:    partial_d[15:8]  = i_serialized_output;
                2'd2:    partial_d[23:16] = i_serialized_output;
                default: word_done        = 1'b1;
              endcase
            end else begin
              lane_err_evt = 1'b1;
              partial_d    = '0;
              if (lane == '0) begin
                partial_d[7:0] = i_serialized_output;
                exp_lane_d     = 2'd1;
                resync_d       = 1'b0;
              end else begin
                exp_lane_d = '0;
                resync_d   = 1'b1;
              end
            end
          end

          if (word_done) begin
            partial_d = '0;
            words_d   = words_q + 1'b1;
            if (!fifo_full || fifo_pop) begin
              fifo_push = 1'b1;
            end else begin
              drop_evt = 1'b1;
            end
            if (words_d == len_q) state_d = StDrain;
          end
        end
        StDrain: begin
          if (fifo_count == '0) state_d = StDone;
        end
        StDone: begin
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    lane_err_d = i_start ? 1'b0 : (lane_err_q | lane_err_evt);
    ovf_d      = i_start ? 1'b0 : (ovf_q | drop_evt);
  end

  // State and frame registers.
  always_ff @(posedge SLOW_CLK) begin
    if (SLOW_RESET) begin
      state_q    <= StIdle;
      len_q      <= '0;
      words_q    <= '0;
      exp_lane_q <= '0;
      resync_q   <= 1'b0;
      partial_q  <= '0;
      lane_err_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      words_q    <= words_d;
      exp_lane_q <= exp_lane_d;
      resync_q   <= resync_d;
      partial_q  <= partial_d;
      lane_err_q <= lane_err_d;
      ovf_q      <= ovf_d;
    end
  end

  // Frame status outputs.
  always_comb begin
    o_word_valid   = !fifo_empty;
    o_frame_done   = (state_q == StDone);
    o_lane_error   = lane_err_q;
    o_overflow     = ovf_q;
    o_words_packed = words_q;
  end

`ifdef SERIAL_BYTE_PACKER_STATS_EN
  logic [15:0] bytes_seen_q;
  logic [7:0]  err_count_q;

  // Saturating statistics, cleared at every frame start.
  always_ff @(posedge SLOW_CLK) begin
    if (SLOW_RESET || i_start) begin
      bytes_seen_q <= '0;
      err_count_q  <= '0;
    end else begin
      if ((state_q == StCollect) && i_serialized_output_valid && (bytes_seen_q != '1)) begin
        bytes_seen_q <= bytes_seen_q + 1'b1;
      end
      // A lane error and a drop cannot coincide, so at most one step per cycle.
      if ((lane_err_evt || drop_evt) && (err_count_q != '1)) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign o_bytes_seen = bytes_seen_q;
  assign o_err_count  = err_count_q;
`else
  assign o_bytes_seen = '0;
  assign o_err_count  = '0;
`endif

endmodule

// File: tb/tb_serial_byte_packer.sv
// Scoreboard bench for serial_byte_packer: expected words are queued as
// bytes are driven and compared as the DUT hands them out.
module tb_serial_byte_packer;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned LEN_W = 6;
`ifdef SERIAL_BYTE_PACKER_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic             SLOW_CLK = 1'b0;
  logic             SLOW_RESET = 1'b1;
  logic             i_start = 1'b0;
  logic [LEN_W-1:0] i_RCC_BUFFER_LENGTH = '0;
  logic [7:0]       i_serialized_output = '0;
  logic             i_serialized_output_valid = 1'b0;
  logic [1:0]       i_Serialize_Counter = '0;
  logic [31:0]      o_word;
  logic             o_word_valid;
  logic             i_word_ready = 1'b0;
  logic             o_frame_done;
  logic             o_lane_error;
  logic             o_overflow;
  logic [LEN_W:0]   o_words_packed;
  logic [15:0]      o_bytes_seen;
  logic [7:0]       o_err_count;

  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q [$];

  serial_byte_packer #(
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (LEN_W)
  ) dut (
    .SLOW_CLK                  (SLOW_CLK),
    .SLOW_RESET                (SLOW_RESET),
    .i_start                   (i_start),
    .i_RCC_BUFFER_LENGTH       (i_RCC_BUFFER_LENGTH),
    .i_serialized_output       (i_serialized_output),
    .i_serialized_output_valid (i_serialized_output_valid),
    .i_Serialize_Counter       (i_Serialize_Counter),
    .o_word                    (o_word),
    .o_word_valid              (o_word_valid),
    .i_word_ready              (i_word_ready),
    .o_frame_done              (o_frame_done),
    .o_lane_error              (o_lane_error),
    .o_overflow                (o_overflow),
    .o_words_packed            (o_words_packed),
    .o_bytes_seen              (o_bytes_seen),
    .o_err_count               (o_err_count)
  );

  always #5 SLOW_CLK = ~SLOW_CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: count done pulses, pop the scoreboard on each accepted word.
  always @(negedge SLOW_CLK) begin
    if (!SLOW_RESET) begin
      if (o_frame_done) done_cnt++;
      if (o_word_valid && i_word_ready) begin
        if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
        else check_eq("word", o_word, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge SLOW_CLK);
    #1;
  endtask

  task automatic start_frame(input logic [LEN_W-1:0] len);
    i_start = 1'b1;
    i_RCC_BUFFER_LENGTH = len;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic [1:0] lane);
    i_serialized_output = b;
    i_Serialize_Counter = lane;
    i_serialized_output_valid = 1'b1;
    tick();
    i_serialized_output_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_out);
    if (expect_out) exp_q.push_back(w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], 2'(i));
  endtask

  task automatic wait_done(input string tag, input int base, input int budget);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check_eq(tag, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic check_stats(input string tag, input int bytes, input int errs);
    check_eq({tag, "_bytes"}, 32'(o_bytes_seen), StatsEn ? 32'(bytes) : 32'd0);
    check_eq({tag, "_errs"}, 32'(o_err_count), StatsEn ? 32'(errs) : 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    logic [31:0] w;

    repeat (3) tick();
    check_eq("rst_word", o_word, 32'd0);
    check_eq("rst_valid", 32'(o_word_valid), 32'd0);
    check_eq("rst_done", 32'(o_frame_done), 32'd0);
    check_eq("rst_lane_err", 32'(o_lane_error), 32'd0);
    check_eq("rst_ovf", 32'(o_overflow), 32'd0);
    check_eq("rst_words", 32'(o_words_packed), 32'd0);
    check_stats("rst", 0, 0);
    SLOW_RESET = 1'b0;
    tick();

    // Basic two-word frame.
    base = done_cnt;
    i_word_ready = 1'b1;
    start_frame(6'd2);
    send_word(32'h44332211, 1'b1);
    send_word(32'h88776655, 1'b1);
    wait_done("t1_done", base, 50);
    check_eq("t1_lane_err", 32'(o_lane_error), 32'd0);
    check_eq("t1_ovf", 32'(o_overflow), 32'd0);
    check_eq("t1_words", 32'(o_words_packed), 32'd2);
    check_stats("t1", 8, 0);
    check_eq("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Lane sequence error: 0,1,3 then a clean word.
    base = done_cnt;
    start_frame(6'd1);
    send(8'hA0, 2'd0);
    send(8'hA1, 2'd1);
    send(8'hA3, 2'd3);
    send_word(32'hB3B2B1B0, 1'b1);
    wait_done("t2_done", base, 50);
    check_eq("t2_lane_err", 32'(o_lane_error), 32'd1);
    check_eq("t2_words", 32'(o_words_packed), 32'd1);
    check_stats("t2", 7, 1);

    // Overflow: consumer stalled, four words into a two-deep FIFO.
    base = done_cnt;
    i_word_ready = 1'b0;
    start_frame(6'd4);
    check_eq("t3_lane_err_clr", 32'(o_lane_error), 32'd0);
    for (int i = 0; i < 4; i++) begin
      w = 32'h10203040 + 32'(i) * 32'h01010101;
      send_word(w, i < DEPTH);
    end
    check_eq("t3_ovf", 32'(o_overflow), 32'd1);
    check_eq("t3_words", 32'(o_words_packed), 32'd4);
    check_eq("t3_head", o_word, 32'h10203040);
    check_stats("t3", 16, 2);
    i_word_ready = 1'b1;
    wait_done("t3_done", base, 50);
    check_eq("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Full FIFO, lane-3 byte coincides with a pop: no drop.
    base = done_cnt;
    i_word_ready = 1'b0;
    start_frame(6'd3);
    send_word(32'hCAFE0001, 1'b1);
    send_word(32'hCAFE0002, 1'b1);
    exp_q.push_back(32'hCAFE0003);
    send(8'h03, 2'd0);
    send(8'h00, 2'd1);
    send(8'hFE, 2'd2);
    i_word_ready = 1'b1;
    send(8'hCA, 2'd3);
    check_eq("t4_ovf", 32'(o_overflow), 32'd0);
    wait_done("t4_done", base, 50);
    check_eq("t4_ovf_end", 32'(o_overflow), 32'd0);
    check_eq("t4_words", 32'(o_words_packed), 32'd3);
    check_stats("t4", 12, 0);
    check_eq("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Length 0 means 64 words.
    base = done_cnt;
    start_frame(6'd0);
    for (int i = 0; i < 63; i++) send_word($urandom, 1'b1);
    check_eq("t5_words63", 32'(o_words_packed), 32'd63);
    repeat (3) tick();
    check_eq("t5_no_early_done", 32'(done_cnt - base), 32'd0);
    send_word($urandom, 1'b1);
    wait_done("t5_done", base, 50);
    check_eq("t5_words", 32'(o_words_packed), 32'd64);
    check_stats("t5", 256, 0);

    // Abort mid-frame: FIFO flushed, no done pulse for the aborted frame.
    base = done_cnt;
    i_word_ready = 1'b0;
    start_frame(6'd2);
    send_word(32'hDEAD0001, 1'b0);
    send(8'h11, 2'd0);
    send(8'h22, 2'd1);
    check_eq("t6_pre_valid", 32'(o_word_valid), 32'd1);
    check_eq("t6_pre_words", 32'(o_words_packed), 32'd1);
    start_frame(6'd1);
    check_eq("t6_flush_valid", 32'(o_word_valid), 32'd0);
    check_eq("t6_flush_words", 32'(o_words_packed), 32'd0);
    check_stats("t6_clr", 0, 0);
    i_word_ready = 1'b1;
    send_word(32'h0BADF00D, 1'b1);
    wait_done("t6_done", base, 50);
    check_eq("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame discards FIFO contents.
    i_word_ready = 1'b0;
    start_frame(6'd2);
    send_word(32'h5A5A5A5A, 1'b0);
    check_eq("t7_pre_valid", 32'(o_word_valid), 32'd1);
    SLOW_RESET = 1'b1;
    tick();
    check_eq("t7_rst_valid", 32'(o_word_valid), 32'd0);
    check_eq("t7_rst_word", o_word, 32'd0);
    check_eq("t7_rst_words", 32'(o_words_packed), 32'd0);
    SLOW_RESET = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
